// File: rtl/clk_period_meter.sv
// Measures the toggle interval of a slow clock, reported as a divider upperbound.
// Ports: clk, rst_n, clkdiv_in, enable -> upperbound, meas_valid, tick, locked, timeout.
module clk_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clkdiv_in,
  input  logic        enable,
  output logic [31:0] upperbound,
  output logic        meas_valid,
  output logic        tick,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE
  } state_t;

  localparam logic [31:0] CNT_MAX = TIMEOUT - 32'd1;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   sync;
  logic                   edge_hit;

  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [31:0] cnt_inc;
  logic [31:0] ub_nxt;
  logic        mv_nxt;
  logic        tick_nxt;
  logic        lk_nxt;
  logic        to_nxt;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign edge_hit = sync ^ prev;

  // Counting stops at CNT_MAX so a stalled input can never wrap.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clkdiv_in};
      prev   <= sync;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ub_nxt    = upperbound;
    mv_nxt    = 1'b0;
    lk_nxt    = locked;
    to_nxt    = timeout;
    tick_nxt  = edge_hit && (state != IDLE);
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      lk_nxt    = 1'b0;
      to_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          cnt_nxt   = '0;
        end
        ACQUIRE: begin
          // First interval after start/timeout has no known origin.
          if (edge_hit) begin
            state_nxt = MEASURE;
            cnt_nxt   = '0;
            to_nxt    = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        MEASURE: begin
          unique case (1'b1)
            edge_hit: begin
              ub_nxt  = cnt;
              mv_nxt  = 1'b1;
              lk_nxt  = (cnt == upperbound);
              cnt_nxt = '0;
            end
            (cnt == CNT_MAX): begin
              state_nxt = ACQUIRE;
              to_nxt    = 1'b1;
              lk_nxt    = 1'b0;
            end
            default: begin
              cnt_nxt = cnt_inc;
            end
          endcase
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      upperbound <= '0;
      meas_valid <= 1'b0;
      tick       <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      upperbound <= ub_nxt;
      meas_valid <= mv_nxt;
      tick       <= tick_nxt;
      locked     <= lk_nxt;
      timeout    <= to_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter.
// Drives a behavioural divider and checks every meas_valid against a queue.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clkdiv_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] upperbound;
  logic        meas_valid;
  logic        tick;
  logic        locked;
  logic        timeout;

  clk_period_meter #(
    .SYNC_STAGES(2),
    .TIMEOUT(32'd50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clkdiv_in(clkdiv_in),
    .enable(enable),
    .upperbound(upperbound),
    .meas_valid(meas_valid),
    .tick(tick),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ub;
    logic        lk;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ticks = 0;
  int   idle_win = 0;
  int   idle_hits = 0;
  int   div_u = 0;
  int   div_left = 0;
  int   div_cnt = 0;
  int   c;
  int   t0;

  // Divider: with div_u = U it toggles every U+1 clk cycles.
  initial begin : divider
    forever begin
      @(posedge clk);
      #1;
      if (div_left > 0) begin
        if (div_cnt == div_u) begin
          clkdiv_in = ~clkdiv_in;
          div_cnt = 0;
          div_left--;
        end else begin
          div_cnt++;
        end
      end else begin
        div_cnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tick) ticks++;
      if (idle_win != 0 && (meas_valid || tick)) idle_hits++;
      if (meas_valid) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: got ub=%0d lk=%0d, required none",
                   upperbound, locked);
        end else begin
          e = sbq.pop_front();
          if (upperbound !== e.ub || locked !== e.lk) begin
            n_bad++;
            $display("FAIL meas: got ub=%0d lk=%0d, required ub=%0d lk=%0d",
                     upperbound, locked, e.ub, e.lk);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got wait expired required event", nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ub, input logic lk, input int n);
    exp_t x;
    x.ub = ub;
    x.lk = lk;
    repeat (n) sbq.push_back(x);
  endtask

  task automatic wait_left0();
    int k;
    k = 0;
    while (div_left != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (div_left != 0) bound_fail("divider_done");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) bound_fail("scoreboard_drain");
    cycles(2);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 500);
    if (!tick) bound_fail("tick_wait");
  endtask

  task automatic restart();
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles(3);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cycles(3);
    chk("rst_ub", upperbound, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_tick", tick, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    cycles(2);

    // U=3: first toggle discarded, six measurements.
    enable = 1'b1;
    cycles(3);
    push(3, 1'b0, 1);
    push(3, 1'b1, 5);
    t0 = ticks;
    div_u = 3;
    div_left = 7;
    wait_tick(c);
    wait_tick(c);
    chk("tick_period_u3", c, 4);
    wait_left0();
    wait_tick(c);
    c = 0;
    while (!timeout && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_delay", c, 50);
    chk("tick_count_u3", ticks - t0, 7);
    chk("to_locked", locked, 0);
    chk("to_ub_hold", upperbound, 3);
    chk("to_queue_empty", sbq.size(), 0);

    // Restart after timeout at U=5.
    push(5, 1'b0, 1);
    push(5, 1'b1, 2);
    div_u = 5;
    div_left = 4;
    wait_tick(c);
    chk("timeout_clear", timeout, 0);
    wait_left0();
    drain();

    // U=0: toggles every cycle.
    enable = 1'b0;
    cycles(3);
    chk("idle_locked", locked, 0);
    chk("idle_timeout", timeout, 0);
    chk("idle_ub_hold", upperbound, 5);
    enable = 1'b1;
    cycles(3);
    push(0, 1'b0, 1);
    push(0, 1'b1, 3);
    t0 = ticks;
    div_u = 0;
    div_left = 5;
    c = 0;
    while (!meas_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!meas_valid) bound_fail("u0_valid");
    c = 0;
    repeat (3) begin
      @(negedge clk);
      if (meas_valid) c++;
    end
    chk("valid_every_cycle", c, 3);
    wait_left0();
    drain();
    chk("tick_count_u0", ticks - t0, 5);

    // Switch U 3 -> 9 while running.
    restart();
    push(3, 1'b0, 1);
    push(3, 1'b1, 2);
    div_u = 3;
    div_left = 4;
    wait_left0();
    push(9, 1'b0, 1);
    push(9, 1'b1, 3);
    div_u = 9;
    div_left = 4;
    wait_left0();

    // Disable for 20 cycles mid-interval.
    push(9, 1'b1, 2);
    div_left = 10;
    c = 0;
    while (div_left != 8 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (div_left != 8) bound_fail("toggle_wait");
    cycles(5);
    enable = 1'b0;
    idle_win = 1;
    cycles(20);
    idle_win = 0;
    chk("dis_locked", locked, 0);
    chk("dis_ub_hold", upperbound, 9);
    chk("dis_timeout", timeout, 0);
    push(9, 1'b1, 5);
    enable = 1'b1;
    wait_left0();
    drain();
    chk("idle_pulses", idle_hits, 0);

    // Asynchronous reset mid-count.
    restart();
    push(3, 1'b0, 1);
    push(3, 1'b1, 1);
    div_u = 3;
    div_left = 3;
    wait_left0();
    drain();
    chk("pre_rst_locked", locked, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ub", upperbound, 0);
    chk("arst_locked", locked, 0);
    chk("arst_mv", meas_valid, 0);
    chk("arst_tick", tick, 0);
    chk("arst_timeout", timeout, 0);
    clkdiv_in = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    push(3, 1'b0, 1);
    push(3, 1'b1, 1);
    div_left = 3;
    wait_left0();
    drain();
    chk("final_queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Inverse of the clock divider: samples a divided/toggling clock signal in the `clk` domain and recovers its toggle interval as an `upperbound` value.
- Output uses the same encoding as the divider's `upperbound` input: a divider loaded with U toggles every U+1 cycles, and this block reports U.
- Used to verify and auto-track game-tick / gravity dividers.
- Also emits a one-cycle tick pulse per toggle, for logic that needs an enable rather than a derived clock.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer (minimum 2).
- TIMEOUT, 32'd100_000_000, number of cycles without a toggle before `timeout` asserts (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clkdiv_in  input  1  divided clock to measure; may be asynchronous to clk.
- enable  input  1  measurement enable; low forces IDLE.
- upperbound  output  32  last measured interval minus 1.
- meas_valid  output  1  one-cycle pulse when `upperbound` is updated.
- tick  output  1  one-cycle pulse per detected toggle (either edge).
- locked  output  1  two consecutive measurements are equal.
- timeout  output  1  no toggle seen for TIMEOUT cycles.

Behaviour:
- Reset (async on rst_n=0, all flops):
  - upperbound=0; meas_valid=0; tick=0; locked=0; timeout=0.
  - cnt=0; synchronizer chain and prev=0; state=IDLE.
- Edge detect:
  - sync = last synchronizer stage; edge = sync ^ prev; prev <= sync every cycle, in all states.
  - Detection latency is a constant SYNC_STAGES+1 cycles, so measured intervals are exact.
- tick = edge registered; asserts 1 cycle after edge, in every state except IDLE.
- cnt: 32-bit. Cleared to 0 on an edge cycle, otherwise incremented. At an edge, cnt equals N-1, where N is the number of cycles between edges.
- IDLE:
  - cnt held 0; no pulses; locked=0; timeout=0; upperbound holds its value.
  - enable=1 -> ACQUIRE.
- ACQUIRE:
  - Waiting for the first edge; cnt counts.
  - edge -> MEASURE with cnt=0, no meas_valid. The first interval is unknown, so it is discarded.
- MEASURE, on edge:
  - upperbound <= cnt; meas_valid=1 on the next cycle, coincident with the new upperbound value.
  - locked <= (cnt == upperbound_old) on the same update.
  - cnt <= 0.
- MEASURE, no edge and cnt == TIMEOUT-1:
  - Next cycle: timeout=1, locked=0; go to ACQUIRE. cnt saturates/holds.
  - upperbound keeps its last value.
- timeout clears on the cycle the next edge is detected; the block then follows the ACQUIRE rule (first interval discarded).
- enable deasserted in any state:
  - Next cycle: IDLE; in-flight count discarded; no meas_valid.
  - A pending meas_valid/tick already registered still completes.
- Edge on the same cycle as a timeout check: edge wins; it is a normal measurement, no timeout.
- Wrap: cnt cannot wrap, since TIMEOUT bounds it and TIMEOUT ≤ 2^32-1.
- Reset mid-measurement returns everything to reset values immediately, regardless of clk.

Test Plan:
- Divider U=3 driving clkdiv_in, enable=1 -> first toggle discarded; then meas_valid every 4 cycles with upperbound=3; locked=1 from the second valid onward; tick period 4.
- U=0 (toggle every cycle) -> upperbound=0, meas_valid and tick every cycle, locked=1 after 2 measurements.
- Switch U 3->9 mid-run -> one measurement in the 4..10 range with locked=0, then upperbound=9; locked reasserts on the second consecutive 9.
- TIMEOUT=50, stop clkdiv_in -> timeout=1 exactly 50 cycles after the last edge detection, locked=0, upperbound held at 3. Restart toggles -> timeout clears on the first edge; next valid reports the new interval.
- enable low for 20 cycles mid-interval -> no meas_valid/tick during IDLE. Re-enable -> first interval discarded again.
- Assert rst_n=0 asynchronously (between clk edges) mid-count -> all outputs 0 immediately. Release -> no meas_valid until the second edge after enable.
